// File: rtl/frame_pixel_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// frame_pixel_sequencer_pkg
// Shared definitions for the frame pixel sequencer slice: the image window
// bounds, image geometry, the sequencer state enum and the pixel tag that
// rides the read-latency delay line alongside each memory read.
// Optional feature macro used by the slice: ADDR_CHECK_EN (address continuity
// checking in the top module).
// -----------------------------------------------------------------------------
package frame_pixel_sequencer_pkg;

   localparam int ADDR_W  = 18;
   localparam int COORD_W = 8;

   localparam logic [ADDR_W-1:0] START_ADDR = 18'd160000;
   localparam logic [ADDR_W-1:0] END_ADDR   = 18'd199999;

   localparam int IMG_W = 200;
   localparam int IMG_H = (int'(END_ADDR) - int'(START_ADDR) + 1) / IMG_W;

   localparam logic [COORD_W-1:0] X_LAST = COORD_W'(IMG_W - 1);
   localparam logic [COORD_W-1:0] Y_LAST = COORD_W'(IMG_H - 1);

   typedef enum logic {
      SYNC,
      STREAM
   } seq_state_t;

   typedef struct packed {
      logic               valid;
      logic [COORD_W-1:0] x;
      logic [COORD_W-1:0] y;
      logic               sof;
      logic               eol;
      logic               eof;
   } pixel_tag_t;

   // True when the address lies inside the image window.
   function automatic logic in_window(input logic [ADDR_W-1:0] a);
      return (a >= START_ADDR) && (a <= END_ADDR);
   endfunction

endpackage

// File: rtl/frame_pixel_sequencer_if.sv
// -----------------------------------------------------------------------------
// frame_pixel_sequencer_if
// Pixel stream bundle produced by frame_pixel_sequencer.
//   pix_data   pixel value (DATA_W)
//   pix_valid  pixel fields valid this cycle
//   pix_x/y    column / row of the pixel
//   sof/eol/eof frame and line markers
//   frame_cnt  completed frame count
//   addr_err   sticky address-discontinuity flag
// master: the sequencer driving the stream; slave: the downstream consumer.
// -----------------------------------------------------------------------------
interface frame_pixel_sequencer_if #(
   parameter int DATA_W = 8
);
   import frame_pixel_sequencer_pkg::*;

   logic [DATA_W-1:0]  pix_data;
   logic               pix_valid;
   logic [COORD_W-1:0] pix_x;
   logic [COORD_W-1:0] pix_y;
   logic               sof;
   logic               eol;
   logic               eof;
   logic [15:0]        frame_cnt;
   logic               addr_err;

   modport master (
      output pix_data, pix_valid, pix_x, pix_y, sof, eol, eof, frame_cnt, addr_err
   );

   modport slave (
      input  pix_data, pix_valid, pix_x, pix_y, sof, eol, eof, frame_cnt, addr_err
   );

endinterface

// File: rtl/frame_pixel_sequencer_tag_delay_line.sv
// -----------------------------------------------------------------------------
// tag_delay_line
// Fixed-depth shift register carrying pixel tags so each tag emerges in step
// with the memory read data for the address it was issued against.
//   clk, rst  clock and asynchronous active-high reset (clears every stage)
//   tag_in    tag issued this cycle
//   tag_out   tag issued DEPTH cycles earlier
// -----------------------------------------------------------------------------
module tag_delay_line
   import frame_pixel_sequencer_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  pixel_tag_t tag_in,
   output pixel_tag_t tag_out
);

   pixel_tag_t stages [DEPTH];

   // Shift every stage one step per clock; reset empties the whole line so
   // no stale tag can surface after a reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            stages[i] <= '0;
         end
      end else begin
         stages[0] <= tag_in;
         for (int i = 1; i < DEPTH; i++) begin
            stages[i] <= stages[i-1];
         end
      end
   end

   assign tag_out = stages[DEPTH-1];

endmodule

// File: rtl/frame_pixel_sequencer.sv
// -----------------------------------------------------------------------------
// frame_pixel_sequencer
// Tags the free-running frame address stream with x/y coordinates and frame
// markers, delays the tags by the memory read latency and registers them with
// the returning read data into a pixel stream.
//   clk, rst   clock, asynchronous active-high reset
//   addr_in    address currently driven to the image memory
//   rd_data    memory read data, valid RD_LATENCY cycles after its address
//   pix        pixel stream (frame_pixel_sequencer_if.master)
// Parameters: DATA_W pixel width, RD_LATENCY memory latency (legal 1..4).
// Build option: define ADDR_CHECK_EN to enable address continuity checking
// with a sticky addr_err flag; otherwise addr_err is tied low.
// -----------------------------------------------------------------------------
module frame_pixel_sequencer
   import frame_pixel_sequencer_pkg::*;
#(
   parameter int DATA_W     = 8,
   parameter int RD_LATENCY = 2
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [ADDR_W-1:0]       addr_in,
   input  logic [DATA_W-1:0]       rd_data,
   frame_pixel_sequencer_if.master pix
);

   seq_state_t         state_q, state_d;
   logic [COORD_W-1:0] x_q, y_q, x_d, y_d;
   logic [COORD_W-1:0] adv_x, adv_y;
   pixel_tag_t         adv_tag, tag_d, tag_out;

   logic [DATA_W-1:0]  data_q;
   logic               valid_q, sof_q, eol_q, eof_q;
   logic [COORD_W-1:0] px_q, py_q;
   logic [15:0]        frame_cnt_q;

`ifdef ADDR_CHECK_EN
   logic [ADDR_W-1:0]  last_addr_q, last_addr_d, expected_addr;
   logic               mismatch, addr_err_q;
`endif

   // Coordinates and tag the current address would get if the stream simply
   // advances: START_ADDR always restarts at the origin, otherwise step along
   // the line and wrap into the next row. Out-of-window addresses still move
   // the coordinates but never yield a valid tag.
   always_comb begin
      adv_x   = '0;
      adv_y   = '0;
      adv_tag = '0;
      if (addr_in == START_ADDR) begin
         adv_x = '0;
         adv_y = '0;
      end else if (x_q == X_LAST) begin
         adv_x = '0;
         adv_y = (y_q == Y_LAST) ? '0 : y_q + 8'd1;
      end else begin
         adv_x = x_q + 8'd1;
         adv_y = y_q;
      end
      if (in_window(addr_in)) begin
         adv_tag.valid = 1'b1;
         adv_tag.x     = adv_x;
         adv_tag.y     = adv_y;
         adv_tag.sof   = (addr_in == START_ADDR);
         adv_tag.eol   = (adv_x == X_LAST) || (addr_in == END_ADDR);
         adv_tag.eof   = (addr_in == END_ADDR);
      end
   end

   // Next-state and tag issue. SYNC waits for the start of a frame; STREAM
   // tags every cycle. With checking enabled a broken address sequence drops
   // back to SYNC without tagging, and the offending address is never used to
   // resynchronize in the same cycle even if it happens to be START_ADDR.
   always_comb begin
      state_d = state_q;
      x_d     = x_q;
      y_d     = y_q;
      tag_d   = '0;
`ifdef ADDR_CHECK_EN
      last_addr_d   = last_addr_q;
      expected_addr = (last_addr_q == END_ADDR) ? START_ADDR : last_addr_q + 18'd1;
      mismatch      = 1'b0;
`endif
      unique case (state_q)
         SYNC: begin
            if (addr_in == START_ADDR) begin
               state_d   = STREAM;
               x_d       = '0;
               y_d       = '0;
               tag_d     = adv_tag;
`ifdef ADDR_CHECK_EN
               last_addr_d = addr_in;
`endif
            end
         end
         STREAM: begin
`ifdef ADDR_CHECK_EN
            if (addr_in != expected_addr) begin
               mismatch = 1'b1;
               state_d  = SYNC;
            end else begin
               x_d         = adv_x;
               y_d         = adv_y;
               tag_d       = adv_tag;
               last_addr_d = addr_in;
            end
`else
            x_d   = adv_x;
            y_d   = adv_y;
            tag_d = adv_tag;
`endif
         end
      endcase
   end

   // State and coordinate registers; x/y hold the coordinates of the most
   // recently tagged address.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= SYNC;
         x_q     <= '0;
         y_q     <= '0;
      end else begin
         state_q <= state_d;
         x_q     <= x_d;
         y_q     <= y_d;
      end
   end

`ifdef ADDR_CHECK_EN
   // Continuity tracking: remember the last accepted address and latch any
   // discontinuity until the next reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         last_addr_q <= '0;
         addr_err_q  <= 1'b0;
      end else begin
         last_addr_q <= last_addr_d;
         if (mismatch) begin
            addr_err_q <= 1'b1;
         end
      end
   end
`endif

   tag_delay_line #(
      .DEPTH (RD_LATENCY)
   ) u_tag_delay_line (
      .clk     (clk),
      .rst     (rst),
      .tag_in  (tag_d),
      .tag_out (tag_out)
   );

   // Output stage: a tag leaving the delay line meets its read data here.
   // Invalid cycles drive zero on every field so downstream never sees junk,
   // and the frame counter steps together with the eof pixel.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid_q     <= 1'b0;
         data_q      <= '0;
         px_q        <= '0;
         py_q        <= '0;
         sof_q       <= 1'b0;
         eol_q       <= 1'b0;
         eof_q       <= 1'b0;
         frame_cnt_q <= '0;
      end else begin
         valid_q <= tag_out.valid;
         data_q  <= tag_out.valid ? rd_data : '0;
         px_q    <= tag_out.x;
         py_q    <= tag_out.y;
         sof_q   <= tag_out.sof;
         eol_q   <= tag_out.eol;
         eof_q   <= tag_out.eof;
         if (tag_out.valid && tag_out.eof) begin
            frame_cnt_q <= frame_cnt_q + 16'd1;
         end
      end
   end

   assign pix.pix_valid = valid_q;
   assign pix.pix_data  = data_q;
   assign pix.pix_x     = px_q;
   assign pix.pix_y     = py_q;
   assign pix.sof       = sof_q;
   assign pix.eol       = eol_q;
   assign pix.eof       = eof_q;
   assign pix.frame_cnt = frame_cnt_q;
`ifdef ADDR_CHECK_EN
   assign pix.addr_err  = addr_err_q;
`else
   assign pix.addr_err  = 1'b0;
`endif

endmodule
